// File: rtl/uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module  : uart_word_packer
// Brief   : Packs 0x80-framed UART bytes MSB-first into DATA_W words and
//           queues them in a first-word-fall-through FIFO. Optional macro
//           UART_PACKER_CHKSUM_EN adds a trailing XOR checksum byte per frame.
// Revision: 1.0 - initial release
// ============================================================================
module uart_word_packer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     rd_en,
  input  logic                     flag_clr,
  output logic [DATA_W-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     status_flag,
  output logic                     ready_flag,
  output logic                     ovf_err,
  output logic                     tmo_err,
  output logic                     chk_err
);

  localparam int c_NBYTES = DATA_W / 8;
  localparam int c_IDX_W  = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
  localparam int c_AW     = $clog2(DEPTH);
  localparam int c_GAP_W  = $clog2(TIMEOUT + 1);
  localparam logic [7:0] c_CMD_LOAD   = 8'h80;
  localparam logic [7:0] c_CMD_STATUS = 8'h40;
  localparam logic [7:0] c_CMD_READY  = 8'h20;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NBYTES - 1);

`ifdef UART_PACKER_CHKSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_CHK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1} state_t;
`endif

  state_t               r_state, w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [DATA_W-1:0]    r_shift, w_shift_nxt, w_word, w_push_data;
  logic [c_GAP_W-1:0]   r_gap;
  logic                 w_gap_hit;
  logic                 w_push, w_pop, w_wr, w_full;
  logic                 w_set_status, w_set_ready, w_set_tmo, w_set_ovf;
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [c_AW-1:0]      r_wptr, r_rptr;
  logic [c_AW:0]        r_level;
  logic                 r_status, r_ready, r_ovf, r_tmo;

  // Word as it looks after shifting in the current byte.
  generate
    if (DATA_W == 8) begin : g_shift_byte
      assign w_word = rx_byte;
    end else begin : g_shift_multi
      assign w_word = {r_shift[DATA_W-9:0], rx_byte};
    end
  endgenerate

`ifdef UART_PACKER_CHKSUM_EN
  logic [7:0] r_xor, w_xor_nxt;
  logic       w_set_chk;
  logic       r_chk;
  assign w_push_data = r_shift;
`else
  assign w_push_data = w_word;
`endif

  // Idle-gap counter saturates at TIMEOUT until the next byte arrives.
  assign w_gap_hit = (r_gap == c_GAP_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || rx_valid) r_gap <= '0;
    else if (!w_gap_hit) r_gap <= r_gap + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_push       = 1'b0;
    w_set_status = 1'b0;
    w_set_ready  = 1'b0;
    w_set_tmo    = 1'b0;
`ifdef UART_PACKER_CHKSUM_EN
    w_xor_nxt    = r_xor;
    w_set_chk    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_byte == c_CMD_LOAD) begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = '0;
            w_shift_nxt = '0;
`ifdef UART_PACKER_CHKSUM_EN
            w_xor_nxt   = '0;
`endif
          end else if (rx_byte == c_CMD_STATUS) begin
            w_set_status = 1'b1;
          end else if (rx_byte == c_CMD_READY) begin
            w_set_ready = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          w_shift_nxt = w_word;
`ifdef UART_PACKER_CHKSUM_EN
          w_xor_nxt   = r_xor ^ rx_byte;
`endif
          if (r_idx == c_LAST_IDX) begin
            w_idx_nxt = '0;
`ifdef UART_PACKER_CHKSUM_EN
            w_state_nxt = ST_CHK;
`else
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else if (w_gap_hit) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_set_tmo   = 1'b1;
        end
      end
`ifdef UART_PACKER_CHKSUM_EN
      ST_CHK: begin
        if (rx_valid) begin
          w_state_nxt = ST_IDLE;
          if (rx_byte == r_xor) w_push    = 1'b1;
          else                  w_set_chk = 1'b1;
        end else if (w_gap_hit) begin
          w_state_nxt = ST_IDLE;
          w_set_tmo   = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

`ifdef UART_PACKER_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) r_xor <= '0;
    else     r_xor <= w_xor_nxt;
  end
`endif

  // A pop frees a slot in the same cycle, so push-while-full-with-pop succeeds.
  assign w_full    = (r_level == (c_AW+1)'(DEPTH));
  assign w_pop     = rd_en && (r_level != '0);
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_set_ovf = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky flags: a set event outranks flag_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= 1'b0;
      r_ready  <= 1'b0;
      r_ovf    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_status <= w_set_status | (r_status & ~flag_clr);
      r_ready  <= w_set_ready  | (r_ready  & ~flag_clr);
      r_ovf    <= w_set_ovf    | (r_ovf    & ~flag_clr);
      r_tmo    <= w_set_tmo    | (r_tmo    & ~flag_clr);
    end
  end

`ifdef UART_PACKER_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) r_chk <= 1'b0;
    else     r_chk <= w_set_chk | (r_chk & ~flag_clr);
  end
  assign chk_err = r_chk;
`else
  assign chk_err = 1'b0;
`endif

  assign empty       = (r_level == '0);
  assign full        = w_full;
  assign level       = r_level;
  assign dout        = empty ? '0 : r_mem[r_rptr];
  assign status_flag = r_status;
  assign ready_flag  = r_ready;
  assign ovf_err     = r_ovf;
  assign tmo_err     = r_tmo;

endmodule
`default_nettype wire

// File: doc/uart_word_packer.md
UART_WORD_PACKER -- requirements
Module: uart_word_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning FIFO word width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO depth in words; legal values are powers of 2 from 2 to 256.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the maximum clk cycles allowed between bytes of one frame.
REQ-004 Clock and reset are decided: clk is the clock; rst is a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit, sole clock.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port rx_valid, input, 1 bit, one-cycle strobe marking a received byte from the UART.
REQ-008 SHALL have port rx_byte, input, 8 bits, received byte, sampled when rx_valid=1.
REQ-009 SHALL have port rd_en, input, 1 bit, FIFO pop request.
REQ-010 SHALL have port dout, output, DATA_W bits, FIFO head word (first-word-fall-through).
REQ-011 SHALL have ports empty and full, outputs, 1 bit each, FIFO status flags.
REQ-012 SHALL have port level, output, clog2(DEPTH)+1 bits, number of words currently stored.
REQ-013 SHALL have ports status_flag and ready_flag, outputs, 1 bit each, sticky command flags.
REQ-014 SHALL have ports ovf_err, tmo_err and chk_err, outputs, 1 bit each, sticky error flags.
REQ-015 SHALL have port flag_clr, input, 1 bit, synchronous clear of all sticky flags.

Function
REQ-016 The state machine SHALL have states IDLE, LOAD and CHK; CHK exists only when checksum is enabled (see Configuration).
REQ-017 In IDLE, rx_byte 0x80 SHALL move the FSM to LOAD with byte index 0.
REQ-018 In IDLE, 0x40 SHALL set status_flag and 0x20 SHALL set ready_flag; any other byte SHALL be ignored.
REQ-019 In LOAD, every byte SHALL be treated as data, including command codes, and shifted in MSB-first.
REQ-020 The byte index SHALL count 0..DATA_W/8-1; on the last byte the FSM SHALL push the word (or go to CHK when checksum is enabled) and return to IDLE.
REQ-021 A word pushed on the edge that accepts its last byte SHALL appear on dout, with empty=0, in the following cycle.
REQ-022 rd_en with empty=0 SHALL pop the head word; rd_en with empty=1 SHALL be ignored and leave level unchanged.
REQ-023 A push while full=1 with no simultaneous pop SHALL drop the word and set ovf_err; a push and a pop in the same cycle SHALL both succeed and leave level unchanged.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; full SHALL equal (level==DEPTH) and empty SHALL equal (level==0).
REQ-025 An idle-gap counter SHALL clear on each rx_valid; if it reaches TIMEOUT while in LOAD or CHK, the partial word SHALL be discarded, tmo_err set and the FSM returned to IDLE.
REQ-026 flag_clr SHALL clear all five sticky flags; a set event in the same cycle SHALL win over flag_clr.

Reset
REQ-027 rst SHALL force state IDLE, clear byte index, gap counter and pointers, and set level=0, empty=1, full=0, all flags 0 and dout=0.
REQ-028 rst asserted mid-frame SHALL discard the partial word; the FIFO contents are lost.

Configuration
REQ-029 When macro UART_PACKER_CHKSUM_EN is defined, a checksum byte SHALL follow the data bytes; the word SHALL be pushed only if the checksum equals the XOR of all data bytes, otherwise it is dropped and chk_err is set.
REQ-030 When UART_PACKER_CHKSUM_EN is undefined, CHK SHALL not exist and chk_err SHALL be tied to 0.

Verification
REQ-031 Send 0x80,0x12,0x34 with DATA_W=16 -> dout=0x1234, empty=0 one cycle after the last byte, level=1.
REQ-032 Send 0x40 then 0x20 in IDLE, then 0x80,0x40,0x20 -> status_flag=1, ready_flag=1, stored word 0x4020.
REQ-033 Push 17 words with DEPTH=16 and no reads -> full=1, ovf_err=1, level=16, head word is the first one sent.
REQ-034 Send 0x80,0xAA, then idle for TIMEOUT cycles -> tmo_err=1, FSM in IDLE, level unchanged.
REQ-035 With UART_PACKER_CHKSUM_EN: send 0x80,0x12,0x34,0x26 -> word 0x1234 stored; send 0x80,0x12,0x34,0x00 -> word dropped, chk_err=1.
REQ-036 Assert rst after 0x80,0x12 -> empty=1, no word stored; then send 0x80,0x56,0x78 -> dout=0x5678.
